// File: rtl/cpu_pkg.sv
// Shared core definitions: stage indices, stall-vector width and the
// priority encoder used to find the oldest requesting stage.
package cpu_pkg;

  localparam int N_STAGES_DEF = 5;
  localparam int STALL_W      = N_STAGES_DEF + 1;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  localparam int MSB_W = 32;
  localparam int IDX_W = 5;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } msb_t;

  // Highest set bit wins; found=0 when the vector is empty.
  function automatic msb_t msb_idx(input logic [MSB_W-1:0] v);
    msb_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 0; k < MSB_W; k++) begin
      if (v[k]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stat_cnt.sv
// Stall statistics: saturating total stall-cycle count, per-episode run
// length and a sticky flag for episodes longer than MAX_STALL cycles.
module pipe_stat_cnt #(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall_any,
  input  logic             i_clr_stats,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_stall_timeout
);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [15:0]      r_run_cnt;
  logic             r_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_run_cnt   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (i_clr_stats) begin
        r_stall_cnt <= '0;
      end else if (i_stall_any && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end

      // Run length saturates so a very long episode never wraps back.
      if (!i_stall_any) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt != '1) begin
        r_run_cnt <= r_run_cnt + 16'd1;
      end

      if (i_clr_stats) begin
        r_timeout <= 1'b0;
      end else if (i_stall_any && (r_run_cnt == 16'(MAX_STALL))) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_stall_cnt     = r_stall_cnt;
  assign o_stall_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// N-stage pipeline stall/flush controller with registered per-stage valid
// bits and stall statistics.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int N_STAGES  = 5,
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_STAGES-1:0] i_stallreq,
  input  logic [N_STAGES-1:0] i_flushreq,
  input  logic                i_clr_stats,
  output logic [N_STAGES:0]   o_stall,
  output logic [N_STAGES-1:0] o_flush,
  output logic [N_STAGES-1:0] o_stage_valid,
  output logic [CNT_W-1:0]    o_stall_cnt,
  output logic                o_stall_timeout
);

  msb_t w_m;
  msb_t w_f;
  logic w_stall_win;
  logic w_flush_win;
  logic [IDX_W:0] w_m_plus1;

  assign w_m = msb_idx(MSB_W'(i_stallreq));
  assign w_f = msb_idx(MSB_W'(i_flushreq));

  // A stall at or below the flushing stage blocks the redirect; the
  // requester keeps flushreq up until it can be honoured.
  assign w_stall_win = w_m.found && (!w_f.found || (w_m.idx >= w_f.idx));
  assign w_flush_win = w_f.found && !w_stall_win;
  assign w_m_plus1   = {1'b0, w_m.idx} + (IDX_W+1)'(1);

  genvar gi;
  generate
    for (gi = 0; gi <= N_STAGES; gi++) begin : g_stall
      assign o_stall[gi] = w_stall_win && ((IDX_W+1)'(gi) <= w_m_plus1);
    end

    for (gi = 0; gi < N_STAGES; gi++) begin : g_flush
      assign o_flush[gi] = (w_stall_win && ((IDX_W+1)'(gi) == w_m_plus1)) ||
                           (w_flush_win && (IDX_W'(gi) < w_f.idx));
    end
  endgenerate

  logic [N_STAGES-1:0] r_stage_valid;
  logic [N_STAGES-1:0] w_valid_src;

  // Stage 0 is refilled from the always-valid PC.
  assign w_valid_src = {r_stage_valid[N_STAGES-2:0], 1'b1};

  generate
    for (gi = 0; gi < N_STAGES; gi++) begin : g_valid
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_stage_valid[gi] <= 1'b0;
        end else if (o_flush[gi]) begin
          r_stage_valid[gi] <= 1'b0;
        end else if (!o_stall[gi+1]) begin
          r_stage_valid[gi] <= w_valid_src[gi];
        end
      end
    end
  endgenerate

  assign o_stage_valid = r_stage_valid;

  pipe_stat_cnt #(
    .CNT_W     (CNT_W),
    .MAX_STALL (MAX_STALL)
  ) u_stat (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_stall_any     (|i_stallreq),
    .i_clr_stats     (i_clr_stats),
    .o_stall_cnt     (o_stall_cnt),
    .o_stall_timeout (o_stall_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: combinational outputs checked inline,
// registered outputs checked by a monitor one edge after each push.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] stallreq;
  logic [4:0] flushreq;
  logic       clr;
  logic [5:0] stall;
  logic [4:0] flush;
  logic [4:0] sv;
  logic [3:0] cnt;
  logic       tout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [4:0] sv;
    logic [3:0] cnt;
    logic       to;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [4:0] exp_sv;
  logic [3:0] exp_cnt;
  logic       exp_to;
  logic [4:0] stall_tab[4];

  always #5 clk = ~clk;

  pipe_ctrl #(
    .N_STAGES  (5),
    .CNT_W     (4),
    .MAX_STALL (3)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_stallreq      (stallreq),
    .i_flushreq      (flushreq),
    .i_clr_stats     (clr),
    .o_stall         (stall),
    .o_flush         (flush),
    .o_stage_valid   (sv),
    .o_stall_cnt     (cnt),
    .o_stall_timeout (tout)
  );

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      $display("txn %s: stage_valid=%b stall_cnt=%0d timeout=%b", mon_e.tag, sv, cnt, tout);
      checks++;
      if (sv !== mon_e.sv) begin
        errors++;
        $display("FAIL %s stage_valid got %b want %b", mon_e.tag, sv, mon_e.sv);
      end
      checks++;
      if (cnt !== mon_e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got %0d want %0d", mon_e.tag, cnt, mon_e.cnt);
      end
      checks++;
      if (tout !== mon_e.to) begin
        errors++;
        $display("FAIL %s stall_timeout got %b want %b", mon_e.tag, tout, mon_e.to);
      end
    end
  end

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.sv  = exp_sv;
    e.cnt = exp_cnt;
    e.to  = exp_to;
    sb.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    stallreq = '0;
    flushreq = '0;
    for (int k = 0; k < n; k++) begin
      exp_sv = {exp_sv[3:0], 1'b1};
      push("idle");
      cycle();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (sv !== 5'b0 || cnt !== 4'd0 || tout !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got sv=%b cnt=%0d to=%b want 00000/0/0", sv, cnt, tout);
    end
    checks++;
    if (stall !== 6'b0 || flush !== 5'b0) begin
      errors++;
      $display("FAIL reset_comb got stall=%b flush=%b want 000000/00000", stall, flush);
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    exp_sv = '0; exp_cnt = '0; exp_to = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_sv = {exp_sv[3:0], 1'b1};
      push("fill");
      cycle();
      checks++;
      if (stall !== 6'b0) begin
        errors++;
        $display("FAIL fill_stall got %b want 000000", stall);
      end
    end
  endtask

  task automatic test_single_stall();
    stallreq = 5'b00010;
    #1;
    checks++;
    if (stall !== 6'b000111) begin
      errors++;
      $display("FAIL stall1_stall got %b want 000111", stall);
    end
    checks++;
    if (flush !== 5'b00100) begin
      errors++;
      $display("FAIL stall1_flush got %b want 00100", flush);
    end
    exp_sv = 5'b11011; exp_cnt = 4'd1;
    push("stall_id");
    cycle();
    idle(3);
  endtask

  task automatic test_flush();
    flushreq = 5'b00100;
    #1;
    checks++;
    if (flush !== 5'b00011 || stall !== 6'b0) begin
      errors++;
      $display("FAIL flush_ex got flush=%b stall=%b want 00011/000000", flush, stall);
    end
    exp_sv = 5'b11100;
    push("flush_ex");
    cycle();
    idle(5);
  endtask

  task automatic test_stall_flush_combo();
    stallreq = 5'b01000;
    flushreq = 5'b00100;
    #1;
    checks++;
    if (stall !== 6'b011111 || flush !== 5'b10000) begin
      errors++;
      $display("FAIL stall_wins got stall=%b flush=%b want 011111/10000", stall, flush);
    end
    exp_sv = 5'b01111; exp_cnt = 4'd2;
    push("stall_wins");
    cycle();
    stallreq = 5'b00010;
    flushreq = 5'b01000;
    #1;
    checks++;
    if (stall !== 6'b0 || flush !== 5'b00111) begin
      errors++;
      $display("FAIL flush_wins got stall=%b flush=%b want 000000/00111", stall, flush);
    end
    exp_sv = 5'b11000; exp_cnt = 4'd3;
    push("flush_wins");
    cycle();
    idle(5);
  endtask

  task automatic test_timeout();
    stall_tab[0] = 5'b11101;
    stall_tab[1] = 5'b11001;
    stall_tab[2] = 5'b10001;
    stall_tab[3] = 5'b00001;
    stallreq = 5'b00001;
    #1;
    checks++;
    if (stall !== 6'b000011 || flush !== 5'b00010) begin
      errors++;
      $display("FAIL stall_if got stall=%b flush=%b want 000011/00010", stall, flush);
    end
    for (int k = 0; k < 3; k++) begin
      exp_sv = stall_tab[k]; exp_cnt = exp_cnt + 4'd1;
      push("stall3");
      cycle();
    end
    idle(5);
    stallreq = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      exp_sv = stall_tab[k]; exp_cnt = exp_cnt + 4'd1; exp_to = (k == 3);
      push("stall4");
      cycle();
    end
    idle(1);
    clr = 1'b1;
    exp_sv = {exp_sv[3:0], 1'b1}; exp_cnt = '0; exp_to = 1'b0;
    push("clr_stats");
    cycle();
    clr = 1'b0;
    idle(2);
  endtask

  task automatic test_saturation();
    stallreq = 5'b00001;
    for (int k = 0; k < 20; k++) begin
      exp_sv  = (k < 4) ? stall_tab[k] : 5'b00001;
      exp_cnt = (exp_cnt == 4'd15) ? 4'd15 : exp_cnt + 4'd1;
      exp_to  = (k >= 3);
      push("sat");
      cycle();
    end
  endtask

  task automatic test_reset_mid_stall();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sv !== 5'b0 || cnt !== 4'd0 || tout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got sv=%b cnt=%0d to=%b want 00000/0/0", sv, cnt, tout);
    end
    checks++;
    if (stall !== 6'b000011) begin
      errors++;
      $display("FAIL reset_stall_comb got %b want 000011", stall);
    end
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    exp_sv = 5'b00000; exp_cnt = 4'd1; exp_to = 1'b0;
    push("post_reset");
    cycle();
    stallreq = '0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    stallreq = '0;
    flushreq = '0;
    clr      = 1'b0;
    test_reset();
    test_single_stall();
    test_flush();
    test_stall_flush_combo();
    test_timeout();
    test_saturation();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after 100000 time units");
    $fatal(1);
  end

endmodule
